// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control block: FSM state encoding and
// the BCD digit limits of the 00-59 seconds counter.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_ctrl_bcd_counter_60.sv
// Live mod-60 two-digit BCD counter. wrap pulses for the one cycle that
// follows the 59->00 step; clr takes priority over en.
module bcd_counter_60
    import stopwatch_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       wrap
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ones <= 4'd0;
            tens <= 4'd0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr) begin
                ones <= 4'd0;
                tens <= 4'd0;
            end else if (en) begin
                if (ones == ONES_MAX) begin
                    ones <= 4'd0;
                    if (tens == TENS_MAX) begin
                        tens <= 4'd0;
                        wrap <= 1'b1;
                    end else begin
                        tens <= tens + 4'd1;
                    end
                end else begin
                    ones <= ones + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: run/pause/lap/clear FSM, 1 Hz prescaler, lap register
// and display mux in front of the live BCD seconds counter.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic       btn_clr,
    output logic [3:0] disp_ones,
    output logic [3:0] disp_tens,
    output logic       running,
    output logic       lap_held,
    output logic       wrap
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_t        state, next_state;
    logic [PW-1:0] prescaler;
    logic [3:0]    cnt_ones, cnt_tens;
    logic [3:0]    lap_ones, lap_tens;
    logic          active, step, lap_capture, cnt_clr;

    assign active = (state == RUN) || (state == LAP);
    assign step   = active && (prescaler == PRE_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Priority clr > ss > lap, applied only among buttons legal in the state.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state  = state;
        lap_capture = 1'b0;
        cnt_clr     = 1'b0;
        case (state)
            IDLE: begin
                if (btn_ss) next_state = RUN;
            end
            RUN: begin
                if (btn_ss) begin
                    next_state = PAUSE;
                end else if (btn_lap) begin
                    next_state  = LAP;
                    lap_capture = 1'b1;
                end
            end
            LAP: begin
                if (btn_ss)       next_state = PAUSE;
                else if (btn_lap) next_state = RUN;
            end
            PAUSE: begin
                if (btn_clr) begin
                    next_state = IDLE;
                    cnt_clr    = 1'b1;
                end else if (btn_ss) begin
                    next_state = RUN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Holds in PAUSE so a resume keeps the fractional second.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (active) begin
            prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + PW'(1);
        end else if (state == IDLE || cnt_clr) begin
            prescaler <= '0;
        end
    end

    // Captures the pre-step count even when the capture edge is a step edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lap_ones <= 4'd0;
            lap_tens <= 4'd0;
        end else if (lap_capture) begin
            lap_ones <= cnt_ones;
            lap_tens <= cnt_tens;
        end
    end

    bcd_counter_60 u_counter (
        .clock (clock),
        .reset (reset),
        .en    (step),
        .clr   (cnt_clr),
        .ones  (cnt_ones),
        .tens  (cnt_tens),
        .wrap  (wrap)
    );

    assign disp_ones = (state == LAP) ? lap_ones : cnt_ones;
    assign disp_tens = (state == LAP) ? lap_tens : cnt_tens;
    assign running   = active;
    assign lap_held  = (state == LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at TICK_DIV=4; expectations are queued as
// stimulus is applied and popped when the outputs are sampled on the falling edge.
module tb_stopwatch_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
    logic [3:0] disp_ones, disp_tens;
    logic       running, lap_held, wrap;

    typedef struct {
        string       tag;
        logic [10:0] value;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    stopwatch_ctrl #(.TICK_DIV(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_ss    (btn_ss),
        .btn_lap   (btn_lap),
        .btn_clr   (btn_clr),
        .disp_ones (disp_ones),
        .disp_tens (disp_tens),
        .running   (running),
        .lap_held  (lap_held),
        .wrap      (wrap)
    );

    always #5 clock = ~clock;

    // Packed status word: {wrap, lap_held, running, tens, ones}
    function automatic logic [10:0] st(input int tens, input int ones,
                                       input logic run, input logic lap,
                                       input logic wr);
        return {wr, lap, run, 4'(tens), 4'(ones)};
    endfunction

    function automatic logic [10:0] secs(input int s, input logic run,
                                         input logic lap, input logic wr);
        return st(s / 10, s % 10, run, lap, wr);
    endfunction

    task automatic expect_st(input string tag, input logic [10:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [10:0] obs;
        obs = {wrap, lap_held, running, disp_tens, disp_ones};
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.value) else begin
                mismatched++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.value);
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Buttons held across exactly one rising edge; returns on the next falling edge.
    task automatic press(input logic ss, input logic lap, input logic clr);
        btn_ss  = ss;
        btn_lap = lap;
        btn_clr = clr;
        @(posedge clock);
        #1;
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
        btn_clr = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values while reset is held
        #2;
        expect_st("reset_hold", st(0, 0, 0, 0, 0));
        check();
        cycles(2);
        reset = 1'b0;

        // Start, then every cycle through the 59->00 rollover
        press(1, 0, 0);
        for (int e = 1; e <= 244; e++) begin
            expect_st("rollover", secs((e / 4) % 60, 1, 0, e == 240));
            cycles(1);
            check();
        end

        // Run on to 37 and assert reset between edges
        cycles(388 - 244);
        expect_st("run_37", secs(37, 1, 0, 0));
        check();
        #2 reset = 1'b1;
        expect_st("reset_async", st(0, 0, 0, 0, 0));
        #1 check();
        @(negedge clock);
        reset = 1'b0;
        expect_st("idle_after_reset", st(0, 0, 0, 0, 0));
        check();
        press(0, 1, 0);
        press(0, 0, 1);
        cycles(4);
        expect_st("idle_ignores_lap_clr", st(0, 0, 0, 0, 0));
        check();

        // Pause preserves prescaler phase
        press(1, 0, 0);
        cycles(5);
        press(1, 0, 0);
        expect_st("pause_e6", secs(1, 0, 0, 0));
        check();
        for (int e = 7; e <= 19; e++) begin
            expect_st("pause_hold", secs(1, 0, 0, 0));
            cycles(1);
            check();
        end
        press(1, 0, 0);
        expect_st("resume_e20", secs(1, 1, 0, 0));
        check();
        expect_st("resume_e21", secs(1, 1, 0, 0));
        cycles(1);
        check();
        expect_st("resume_step_e22", secs(2, 1, 0, 0));
        cycles(1);
        check();

        // Clear ignored in RUN, honoured over ss in PAUSE
        press(0, 0, 1);
        expect_st("clr_in_run", secs(2, 1, 0, 0));
        check();
        expect_st("run_after_clr_e26", secs(3, 1, 0, 0));
        cycles(3);
        check();
        press(1, 0, 0);
        expect_st("pause_e27", secs(3, 0, 0, 0));
        check();
        press(1, 0, 1);
        expect_st("clr_ss_pause", st(0, 0, 0, 0, 0));
        check();
        expect_st("idle_stays_zero", st(0, 0, 0, 0, 0));
        cycles(5);
        check();

        // Lap freeze and release
        press(1, 0, 0);
        expect_st("lap_pre_12", secs(12, 1, 0, 0));
        cycles(48);
        check();
        press(0, 1, 0);
        expect_st("lap_frozen", secs(12, 1, 1, 0));
        check();
        expect_st("lap_frozen_live15", secs(12, 1, 1, 0));
        cycles(11);
        check();
        press(0, 1, 0);
        expect_st("lap_release", secs(15, 1, 0, 0));
        check();
        press(0, 1, 0);
        expect_st("lap_again", secs(15, 1, 1, 0));
        check();
        press(1, 0, 0);
        expect_st("lap_to_pause", secs(15, 0, 0, 0));
        check();
        press(0, 0, 1);
        expect_st("pause_clr", st(0, 0, 0, 0, 0));
        check();

        // Lap coincident with 19->20 step, then ss on a step edge
        press(1, 0, 0);
        expect_st("coinc_pre_19", secs(19, 1, 0, 0));
        cycles(79);
        check();
        press(0, 1, 0);
        expect_st("lap_on_step", secs(19, 1, 1, 0));
        check();
        press(0, 1, 0);
        expect_st("live_after_lap_step", secs(20, 1, 0, 0));
        check();
        cycles(2);
        press(1, 0, 0);
        expect_st("stop_on_step", secs(21, 0, 0, 0));
        check();
        press(1, 0, 0);
        expect_st("resume_after_step_stop", secs(21, 1, 0, 0));
        check();
        expect_st("no_early_step", secs(21, 1, 0, 0));
        cycles(3);
        check();
        expect_st("step_tickdiv_after_resume", secs(22, 1, 0, 0));
        cycles(1);
        check();

        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $error("FAIL scoreboard_leftover: observed %0d pending required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
